// File: rtl/dll_fc_init_gen.sv
// VC0 InitFC1/InitFC2 flow-control initialisation engine (P, NP, Cpl) for the DLCMSM.
// Define DLL_FC_INIT_RESEND_EN to enable periodic resend of each InitFC sequence.
module dll_fc_init_gen #(
    parameter logic [7:0]  HDR_CREDITS   = 8'd32,
    parameter logic [11:0] DATA_CREDITS  = 12'd256,
    parameter int          RESEND_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  dl_state_i,
    input  logic        link_up_i,
    input  logic        rx_dllp_valid_i,
    input  logic [31:0] rx_dllp_i,
    output logic        tx_dllp_valid_o,
    output logic [31:0] tx_dllp_o,
    input  logic        tx_dllp_ready_i,
    output logic        init1_end_o,
    output logic        init2_end_o,
    output logic [7:0]  fc_p_hdr_o,
    output logic [7:0]  fc_np_hdr_o,
    output logic [7:0]  fc_cpl_hdr_o,
    output logic [11:0] fc_p_data_o,
    output logic [11:0] fc_np_data_o,
    output logic [11:0] fc_cpl_data_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I1_SEND = 3'd1,
        I1_WAIT = 3'd2,
        I1_DONE = 3'd3,
        I2_SEND = 3'd4,
        I2_WAIT = 3'd5,
        DONE    = 3'd6
    } state_e;

    localparam logic [1:0] DL_INACTIVE = 2'd0;
    localparam logic [1:0] DL_INIT1    = 2'd1;
    localparam logic [1:0] DL_INIT2    = 2'd2;

    if (RESEND_CYCLES < 4) begin : g_bad_resend
        $error("RESEND_CYCLES must be at least 4");
    end

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic              seq1_q, seq1_d, seq2_q, seq2_d;
    logic [2:0]        flag_q, flag_d;
    logic              fc2_seen_q, fc2_seen_d;
    logic [2:0][7:0]   hdr_q, hdr_d;
    logic [2:0][11:0]  data_q, data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [31:0]       tx_dllp_q, tx_dllp_d;
    logic              init1_end_q, init1_end_d;
    logic              init2_end_q, init2_end_d;

    logic       abort, accept, done1, done2, resend_hit;
    logic       in_init1, in_init2;
    logic [7:0] rx_type;
    logic [1:0] rx_fc;
    logic       rx_ok, rx_init1, rx_init2, rx_upd;
    logic       unused_rx;

    assign abort    = !link_up_i || (dl_state_i == DL_INACTIVE);
    assign accept   = tx_valid_q && tx_dllp_ready_i;
    assign done1    = (&flag_q) && seq1_q;
    assign done2    = fc2_seen_q && seq2_q;
    assign in_init1 = (state_q == I1_SEND) || (state_q == I1_WAIT);
    assign in_init2 = (state_q == I2_SEND) || (state_q == I2_WAIT);

    // Type byte: [7:6] kind (01 InitFC1, 11 InitFC2, 10 UpdateFC), [5:4] P/NP/Cpl, [3:0] VC0.
    assign rx_type   = rx_dllp_i[31:24];
    assign rx_fc     = rx_type[5:4];
    assign rx_ok     = rx_dllp_valid_i && (rx_type[3:0] == 4'h0) && (rx_fc != 2'b11);
    assign rx_init1  = rx_ok && (rx_type[7:6] == 2'b01);
    assign rx_init2  = rx_ok && (rx_type[7:6] == 2'b11);
    assign rx_upd    = rx_ok && (rx_type[7:6] == 2'b10);
    assign unused_rx = ^{rx_dllp_i[23:22], rx_dllp_i[13:12]};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (dl_state_i == DL_INIT1) begin
                    state_d = I1_SEND;
                    idx_d   = 2'd0;
                end
            end
            I1_SEND, I2_SEND: begin
                if (accept) begin
                    if (idx_q == 2'd2) begin
                        state_d = (state_q == I1_SEND) ? I1_WAIT : I2_WAIT;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            I1_WAIT: begin
                if (done1) begin
                    state_d = I1_DONE;
                end else if (resend_hit) begin
                    state_d = I1_SEND;
                    idx_d   = 2'd0;
                end
            end
            I1_DONE: begin
                if (dl_state_i == DL_INIT2) begin
                    state_d = I2_SEND;
                    idx_d   = 2'd0;
                end
            end
            I2_WAIT: begin
                if (done2) begin
                    state_d = DONE;
                end else if (resend_hit) begin
                    state_d = I2_SEND;
                    idx_d   = 2'd0;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            idx_d   = 2'd0;
        end
    end

`ifdef DLL_FC_INIT_RESEND_EN
    localparam int CNT_W = (RESEND_CYCLES > 1) ? $clog2(RESEND_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign resend_hit = (cnt_q == CNT_W'(RESEND_CYCLES - 1));

    // Counts idle cycles only while parked in a WAIT state; any exit restarts it.
    always_comb begin
        cnt_d = '0;
        if (((state_q == I1_WAIT) || (state_q == I2_WAIT)) && (state_d == state_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign resend_hit = 1'b0;
`endif

    // Outputs are computed from the next state so every output is a plain register.
    always_comb begin
        tx_valid_d = (state_d == I1_SEND) || (state_d == I2_SEND);
        tx_dllp_d  = '0;
        if (tx_valid_d)
            tx_dllp_d = {((state_d == I2_SEND) ? 2'b11 : 2'b01), idx_d, 4'h0,
                         2'b00, HDR_CREDITS, 2'b00, DATA_CREDITS};
        init1_end_d = (state_q == I1_WAIT) && (state_d == I1_DONE);
        init2_end_d = (state_q == I2_WAIT) && (state_d == DONE);
        seq1_d      = seq1_q || ((state_q == I1_SEND) && accept && (idx_q == 2'd2));
        seq2_d      = seq2_q || ((state_q == I2_SEND) && accept && (idx_q == 2'd2));
        flag_d      = flag_q;
        hdr_d       = hdr_q;
        data_d      = data_q;
        fc2_seen_d  = fc2_seen_q;
        if (in_init1 && (rx_init1 || rx_init2)) begin
            flag_d[rx_fc] = 1'b1;
            if (!flag_q[rx_fc]) begin
                hdr_d[rx_fc]  = rx_dllp_i[21:14];
                data_d[rx_fc] = rx_dllp_i[11:0];
            end
        end
        if (in_init2 && (rx_init2 || rx_upd))
            fc2_seen_d = 1'b1;
        if (abort) begin
            tx_valid_d  = 1'b0;
            tx_dllp_d   = '0;
            init1_end_d = 1'b0;
            init2_end_d = 1'b0;
            seq1_d      = 1'b0;
            seq2_d      = 1'b0;
            flag_d      = '0;
            hdr_d       = '0;
            data_d      = '0;
            fc2_seen_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            seq1_q      <= 1'b0;
            seq2_q      <= 1'b0;
            flag_q      <= '0;
            fc2_seen_q  <= 1'b0;
            hdr_q       <= '0;
            data_q      <= '0;
            tx_valid_q  <= 1'b0;
            tx_dllp_q   <= '0;
            init1_end_q <= 1'b0;
            init2_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            seq1_q      <= seq1_d;
            seq2_q      <= seq2_d;
            flag_q      <= flag_d;
            fc2_seen_q  <= fc2_seen_d;
            hdr_q       <= hdr_d;
            data_q      <= data_d;
            tx_valid_q  <= tx_valid_d;
            tx_dllp_q   <= tx_dllp_d;
            init1_end_q <= init1_end_d;
            init2_end_q <= init2_end_d;
        end
    end

    assign tx_dllp_valid_o = tx_valid_q;
    assign tx_dllp_o       = tx_dllp_q;
    assign init1_end_o     = init1_end_q;
    assign init2_end_o     = init2_end_q;
    assign fc_p_hdr_o      = hdr_q[0];
    assign fc_np_hdr_o     = hdr_q[1];
    assign fc_cpl_hdr_o    = hdr_q[2];
    assign fc_p_data_o     = data_q[0];
    assign fc_np_data_o    = data_q[1];
    assign fc_cpl_data_o   = data_q[2];

endmodule

// File: tb/tb_dll_fc_init_gen.sv
// Directed bench for dll_fc_init_gen: cycle table for the main Init1/Init2 flow plus
// hand sequences for abort, InitFC2-in-Init1, unknown types, resend and completion.
module tb_dll_fc_init_gen;
    localparam int R = 16;
    localparam logic [31:0] TP1 = 32'h40080100, TN1 = 32'h50080100, TC1 = 32'h60080100;
    localparam logic [31:0] TP2 = 32'hC0080100, TN2 = 32'hD0080100, TC2 = 32'hE0080100;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  dl_state_i = 2'd0;
    logic        link_up_i = 1'b0, rx_dllp_valid_i = 1'b0, tx_dllp_ready_i = 1'b0;
    logic [31:0] rx_dllp_i = '0;
    logic        tx_dllp_valid_o, init1_end_o, init2_end_o;
    logic [31:0] tx_dllp_o;
    logic [7:0]  fc_p_hdr_o, fc_np_hdr_o, fc_cpl_hdr_o;
    logic [11:0] fc_p_data_o, fc_np_data_o, fc_cpl_data_o;

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    dll_fc_init_gen #(.HDR_CREDITS(8'd32), .DATA_CREDITS(12'd256), .RESEND_CYCLES(R)) dut (
        .clk(clk), .rst_n(rst_n), .dl_state_i(dl_state_i), .link_up_i(link_up_i),
        .rx_dllp_valid_i(rx_dllp_valid_i), .rx_dllp_i(rx_dllp_i),
        .tx_dllp_valid_o(tx_dllp_valid_o), .tx_dllp_o(tx_dllp_o), .tx_dllp_ready_i(tx_dllp_ready_i),
        .init1_end_o(init1_end_o), .init2_end_o(init2_end_o),
        .fc_p_hdr_o(fc_p_hdr_o), .fc_np_hdr_o(fc_np_hdr_o), .fc_cpl_hdr_o(fc_cpl_hdr_o),
        .fc_p_data_o(fc_p_data_o), .fc_np_data_o(fc_np_data_o), .fc_cpl_data_o(fc_cpl_data_o)
    );

    typedef struct {
        logic [1:0]  dl;
        logic        link;
        logic [31:0] rx;
        logic        rdy;
        logic [94:0] exp;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic [1:0] dl, logic link, logic [31:0] rx, logic rdy,
                                logic ev, logic [31:0] ed, logic e1, logic e2,
                                logic [7:0] ph, logic [11:0] pd, logic [7:0] nh,
                                logic [11:0] nd, logic [7:0] ch, logic [11:0] cd);
        vec_t v;
        v.dl = dl; v.link = link; v.rx = rx; v.rdy = rdy;
        v.exp = {ev, ed, e1, e2, ph, pd, nh, nd, ch, cd};
        return v;
    endfunction

    function automatic logic [94:0] obs();
        return {tx_dllp_valid_o, tx_dllp_o, init1_end_o, init2_end_o, fc_p_hdr_o, fc_p_data_o,
                fc_np_hdr_o, fc_np_data_o, fc_cpl_hdr_o, fc_cpl_data_o};
    endfunction

    task automatic chk(input string name, input logic [94:0] act, input logic [94:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] dl, input logic link, input logic [31:0] rx, input logic rdy);
        dl_state_i = dl; link_up_i = link; rx_dllp_i = rx;
        rx_dllp_valid_i = (rx != 32'h0); tx_dllp_ready_i = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts valid-low cycles (Init1, ready high) until valid rises, bounded at 100.
    task automatic measure_gap(input logic junk, output int gap, output logic saw_i1);
        gap = 0; saw_i1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_dllp_valid_o) break;
            gap++;
            if (init1_end_o) saw_i1 = 1'b1;
            if (junk && i == 0)      drive(2'd1, 1'b1, 32'h70028064, 1'b1);
            else if (junk && i == 1) drive(2'd1, 1'b1, 32'h30050000, 1'b1);
            else                     drive(2'd1, 1'b1, 32'h0, 1'b1);
            step();
        end
    endtask

    int   gap;
    logic saw, found;

    initial begin
        vecs[0]  = mk(0,0,32'h0,1,        0,32'h0,0,0, 0,0,0,0,0,0);
        vecs[1]  = mk(1,1,32'h0,1,        1,TP1,0,0,   0,0,0,0,0,0);
        vecs[2]  = mk(1,1,32'h0,1,        1,TN1,0,0,   0,0,0,0,0,0);
        vecs[3]  = mk(1,1,32'h0,1,        1,TC1,0,0,   0,0,0,0,0,0);
        vecs[4]  = mk(1,1,32'h0,1,        0,32'h0,0,0, 0,0,0,0,0,0);
        vecs[5]  = mk(1,1,32'h40028064,1, 0,32'h0,0,0, 10,100,0,0,0,0);
        vecs[6]  = mk(1,1,32'h50050000,1, 0,32'h0,0,0, 10,100,20,0,0,0);
        vecs[7]  = mk(1,1,32'h60000000,1, 0,32'h0,0,0, 10,100,20,0,0,0);
        vecs[8]  = mk(1,1,32'h0,1,        0,32'h0,1,0, 10,100,20,0,0,0);
        vecs[9]  = mk(1,1,32'h40014005,1, 0,32'h0,0,0, 10,100,20,0,0,0);
        vecs[10] = mk(2,1,32'h0,0,        1,TP2,0,0,   10,100,20,0,0,0);
        vecs[11] = mk(2,1,32'h0,0,        1,TP2,0,0,   10,100,20,0,0,0);
        vecs[12] = mk(2,1,32'h0,0,        1,TP2,0,0,   10,100,20,0,0,0);
        vecs[13] = mk(2,1,32'h0,1,        1,TN2,0,0,   10,100,20,0,0,0);
        vecs[14] = mk(2,1,32'h90000000,0, 1,TN2,0,0,   10,100,20,0,0,0);
        vecs[15] = mk(2,1,32'h0,0,        1,TN2,0,0,   10,100,20,0,0,0);
        vecs[16] = mk(2,1,32'h0,1,        1,TC2,0,0,   10,100,20,0,0,0);
        vecs[17] = mk(2,1,32'h0,0,        1,TC2,0,0,   10,100,20,0,0,0);
        vecs[18] = mk(2,1,32'h0,0,        1,TC2,0,0,   10,100,20,0,0,0);
        vecs[19] = mk(2,1,32'h0,1,        0,32'h0,0,0, 10,100,20,0,0,0);
        vecs[20] = mk(2,1,32'h0,0,        0,32'h0,0,1, 10,100,20,0,0,0);
        vecs[21] = mk(2,1,32'h0,0,        0,32'h0,0,0, 10,100,20,0,0,0);
        vecs[22] = mk(3,1,32'h0,0,        0,32'h0,0,0, 10,100,20,0,0,0);
        vecs[23] = mk(3,0,32'h0,0,        0,32'h0,0,0, 0,0,0,0,0,0);

        drive(2'd1, 1'b1, 32'h0, 1'b1);
        rst_n = 1'b0;
        step(); step();
        chk("reset", obs(), 95'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].dl, vecs[i].link, vecs[i].rx, vecs[i].rdy);
            step();
            chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end

        // Link drop while NP InitFC1 is pending, then restart from P.
        drive(1, 1, 32'h0, 1); step();
        chk("restart_p", 95'({tx_dllp_valid_o, tx_dllp_o}), 95'({1'b1, TP1}));
        drive(1, 1, 32'h0, 1); step();
        chk("pend_np", 95'({tx_dllp_valid_o, tx_dllp_o}), 95'({1'b1, TN1}));
        drive(1, 1, 32'h4001C007, 0); step();
        chk("hold_np_latch_p", 95'({tx_dllp_valid_o, tx_dllp_o, fc_p_hdr_o, fc_p_data_o}),
            95'({1'b1, TN1, 8'd7, 12'd7}));
        drive(1, 0, 32'h0, 0); step();
        chk("linkdown_clear", obs(), 95'h0);
        drive(1, 1, 32'h0, 1); step();
        chk("relink_p", 95'({tx_dllp_valid_o, tx_dllp_o}), 95'({1'b1, TP1}));

        // InitFC2-Cpl during Init1 sets the Cpl flag and latches; later Cpl value ignored.
        drive(1, 1, 32'hE0030022, 1); step();
        chk("fc2cpl_in_init1", 95'({tx_dllp_valid_o, tx_dllp_o, fc_cpl_hdr_o, fc_cpl_data_o}),
            95'({1'b1, TN1, 8'd12, 12'd34}));
        drive(1, 1, 32'h6000C003, 1); step();
        chk("cpl_first_only", 95'({tx_dllp_valid_o, tx_dllp_o, fc_cpl_hdr_o, fc_cpl_data_o}),
            95'({1'b1, TC1, 8'd12, 12'd34}));
        drive(1, 1, 32'h41024009, 1); step();
        chk("vc1_ignored", 95'({tx_dllp_valid_o, fc_p_hdr_o, fc_p_data_o, fc_cpl_hdr_o}),
            95'({1'b0, 8'd0, 12'd0, 8'd12}));

        measure_gap(1'b1, gap, saw);
        chk("unknown_ignored", 95'({fc_p_hdr_o, fc_p_data_o, fc_np_hdr_o, fc_np_data_o}), 95'h0);
        chk("init1_quiet", 95'(saw), 95'h0);
`ifdef DLL_FC_INIT_RESEND_EN
        chk("resend_gap1", 95'(gap), 95'(R));
        chk("resend_p", 95'({tx_dllp_valid_o, tx_dllp_o}), 95'({1'b1, TP1}));
        drive(1, 1, 32'h0, 1); step();
        chk("resend_np", 95'({tx_dllp_valid_o, tx_dllp_o}), 95'({1'b1, TN1}));
        step();
        chk("resend_cpl", 95'({tx_dllp_valid_o, tx_dllp_o}), 95'({1'b1, TC1}));
        step();
        chk("resend_end", 95'(tx_dllp_valid_o), 95'h0);
        measure_gap(1'b0, gap, saw);
        chk("resend_gap2", 95'(gap), 95'(R));
        chk("init1_quiet2", 95'(saw), 95'h0);
`else
        chk("single_seq", 95'(gap), 95'(100));
`endif

        // Complete Init1 with P and NP; a second P value must not overwrite.
        drive(1, 1, 32'h40024009, 1); step();
        drive(1, 1, 32'h40014005, 1); step();
        chk("p_first_only", 95'({fc_p_hdr_o, fc_p_data_o}), 95'({8'd9, 12'd9}));
        drive(1, 1, 32'h50004002, 1); step();
        drive(1, 1, 32'h0, 1);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (init1_end_o) begin found = 1'b1; break; end
        end
        chk("init1_end_seen", 95'(found), 95'h1);
        chk("credits_after", 95'({fc_np_hdr_o, fc_np_data_o, fc_cpl_hdr_o, fc_cpl_data_o}),
            95'({8'd1, 12'd2, 8'd12, 12'd34}));
        step();
        chk("init1_end_1cyc", 95'({init1_end_o, tx_dllp_valid_o}), 95'h0);

        drive(0, 1, 32'h0, 1); step();
        chk("inactive_clear", obs(), 95'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
